// File: rtl/cs2fifoc_pkg.sv
// Shared definitions for the command-channel frame format.
// The state codes are the same numeric values used by the receive-side
// command-frame parser, so debug dumps of either side read identically.
// Contents: HEAD0/HEAD1 header bytes, frame/payload lengths, state_t codes.
package cs2fifoc_pkg;

  localparam logic [7:0] HEAD0       = 8'h55;
  localparam logic [7:0] HEAD1       = 8'hAA;
  localparam int         FRAME_LEN   = 12;
  localparam int         PAYLOAD_LEN = 9;

  // Byte states HED0..LAST are consecutive codes, so advancing a byte
  // state is a plain +1.
  typedef enum logic [4:0] {
    ST_IDLE = 5'h00,
    ST_LOAD = 5'h01,
    ST_HED0 = 5'h03,
    ST_HED1 = 5'h04,
    ST_CMD0 = 5'h05,
    ST_CMD1 = 5'h06,
    ST_CMD2 = 5'h07,
    ST_CMD3 = 5'h08,
    ST_CMD4 = 5'h09,
    ST_CMD5 = 5'h0A,
    ST_CMD6 = 5'h0B,
    ST_CMD7 = 5'h0C,
    ST_CMD8 = 5'h0D,
    ST_PART = 5'h0E,
    ST_LAST = 5'h0F,
    ST_ERR0 = 5'h14
  } state_t;

endpackage

// File: rtl/cs2fifoc.sv
// cs2fifoc: command-frame transmitter into the command-channel FIFO.
// On fs it snapshots nine payload bytes and writes one 12-byte frame:
//   55 AA p0..p8 chk   (chk = 8-bit sum of p0..p8, headers excluded)
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   fs / fd         frame start request (level) / frame done (LAST)
//   err             high while stuck in ERR0 after a FIFO-full timeout
//   so              current state code for debug
//   fifoc_txen/txd  FIFO write port (combinational)
//   fifoc_full      FIFO full; a byte is written only while it is low
//   kind_dev..cmd_mix1  payload bytes in frame order
module cs2fifoc
  import cs2fifoc_pkg::*;
#(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
  input  logic       clk,
  input  logic       rst,
  output logic       err,
  input  logic       fs,
  output logic       fd,
  output logic [7:0] so,
  output logic       fifoc_txen,
  output logic [7:0] fifoc_txd,
  input  logic       fifoc_full,
  input  logic [7:0] kind_dev,
  input  logic [7:0] info_sr,
  input  logic [7:0] cmd_filt,
  input  logic [7:0] cmd_mix0,
  input  logic [7:0] cmd_reg4,
  input  logic [7:0] cmd_reg5,
  input  logic [7:0] cmd_reg6,
  input  logic [7:0] cmd_reg7,
  input  logic [7:0] cmd_mix1
);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       shadow [PAYLOAD_LEN];
  logic [7:0]       check;
  logic [TMO_W-1:0] stall_cnt;

  logic             byte_st;
  logic             is_cmd;
  logic [3:0]       cmd_idx;
  logic [7:0]       tx_byte;

  // Additive checksum, modulo 256 (carry out discarded).
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign cmd_idx = 4'(state - ST_CMD0);

  always_comb begin
    state_nxt = state;
    byte_st   = 1'b0;
    is_cmd    = 1'b0;
    tx_byte   = 8'h00;
    case (state)
      ST_IDLE: if (fs) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_HED0;
      ST_HED0: begin
        byte_st = 1'b1;
        tx_byte = HEAD0;
      end
      ST_HED1: begin
        byte_st = 1'b1;
        tx_byte = HEAD1;
      end
      ST_CMD0, ST_CMD1, ST_CMD2, ST_CMD3, ST_CMD4,
      ST_CMD5, ST_CMD6, ST_CMD7, ST_CMD8: begin
        byte_st = 1'b1;
        is_cmd  = 1'b1;
        tx_byte = shadow[cmd_idx];
      end
      ST_PART: begin
        byte_st = 1'b1;
        tx_byte = check;
      end
      // Hold done until the requester drops fs, so a level-held fs
      // cannot launch a second frame.
      ST_LAST: if (!fs) state_nxt = ST_IDLE;
      ST_ERR0: state_nxt = ST_ERR0;
      default: state_nxt = ST_IDLE;
    endcase

    if (byte_st) begin
      if (!fifoc_full) begin
        state_nxt = state_t'(state + 5'd1);
      end else if (stall_cnt + TMO_W'(1) == TMO_MAX) begin
        // This stalled edge is the TMO_MAX-th one in a row.
        state_nxt = ST_ERR0;
      end
    end
  end

  assign fifoc_txen = byte_st && !fifoc_full;
  assign fifoc_txd  = tx_byte;
  assign fd         = (state == ST_LAST);
  assign err        = (state == ST_ERR0);
  assign so         = {3'b000, state};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      check     <= 8'h00;
      stall_cnt <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD) begin
        shadow[0] <= kind_dev;
        shadow[1] <= info_sr;
        shadow[2] <= cmd_filt;
        shadow[3] <= cmd_mix0;
        shadow[4] <= cmd_reg4;
        shadow[5] <= cmd_reg5;
        shadow[6] <= cmd_reg6;
        shadow[7] <= cmd_reg7;
        shadow[8] <= cmd_mix1;
        check     <= 8'h00;
        stall_cnt <= '0;
      end else if (byte_st) begin
        if (!fifoc_full) begin
          stall_cnt <= '0;
          if (is_cmd) check <= csum_add(check, tx_byte);
        end else begin
          stall_cnt <= stall_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cs2fifoc.sv
module tb_cs2fifoc;

  logic       clk = 1'b0;
  logic       rst;
  logic       err;
  logic       fs;
  logic       fd;
  logic [7:0] so;
  logic       fifoc_txen;
  logic [7:0] fifoc_txd;
  logic       fifoc_full;
  logic [7:0] kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4;
  logic [7:0] cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1;

  cs2fifoc #(.TMO_W(16), .TMO_MAX(16'd8)) dut (
    .clk(clk), .rst(rst), .err(err), .fs(fs), .fd(fd), .so(so),
    .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd), .fifoc_full(fifoc_full),
    .kind_dev(kind_dev), .info_sr(info_sr), .cmd_filt(cmd_filt),
    .cmd_mix0(cmd_mix0), .cmd_reg4(cmd_reg4), .cmd_reg5(cmd_reg5),
    .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7), .cmd_mix1(cmd_mix1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] payload;
    logic [7:0]  chk;
  } vec_t;

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] cap [$];
  logic [7:0] exp_f [12];

  // Everything the FIFO accepts, in order.
  always @(negedge clk) if (rst && fifoc_txen) cap.push_back(fifoc_txd);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pbyte(input logic [71:0] pl, input int i);
    return pl[71-8*i -: 8];
  endfunction

  task automatic set_payload(input logic [71:0] pl);
    {kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4,
     cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1} = pl;
  endtask

  // Reference frame: two headers, payload in port order, sum mod 256.
  task automatic build_exp(input logic [71:0] pl);
    int sum = 0;
    exp_f[0] = 8'h55;
    exp_f[1] = 8'hAA;
    for (int i = 0; i < 9; i++) begin
      exp_f[2+i] = pbyte(pl, i);
      sum += int'(pbyte(pl, i));
    end
    exp_f[11] = 8'(sum % 256);
  endtask

  task automatic cmp_frame(input string nm);
    chk({nm, " len"}, cap.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < cap.size()) chk($sformatf("%s byte%0d", nm, i), cap[i], exp_f[i]);
  endtask

  task automatic wait_so(input logic [7:0] code, input string nm, inout int cyc);
    int n = 0;
    while (so !== code && n < 60) begin
      step();
      n++;
      cyc++;
    end
    chk(nm, so, code);
  endtask

  // Launch one frame with a one-cycle fs pulse; cyc counts cycles from the
  // edge that sampled fs until fd is seen.
  task automatic send_frame(input logic [71:0] pl, input bit rnd, output int cyc);
    int run = 0;
    cap.delete();
    set_payload(pl);
    fs = 1'b1;
    step();
    fs = 1'b0;
    cyc = 1;
    while (fd !== 1'b1 && cyc < 400) begin
      if (rnd && run < 4 && $urandom_range(0, 2) == 0) begin
        fifoc_full = 1'b1;
        run++;
      end else begin
        fifoc_full = 1'b0;
        run = 0;
      end
      step();
      cyc++;
    end
    fifoc_full = 1'b0;
    chk("frame completes", fd, 1'b1);
    step();
  endtask

  vec_t       tab [5];
  logic [7:0] exp_so [15];
  logic [71:0] pl;
  int          cyc;
  int          cnt;

  initial begin
    tab[0] = '{payload: 72'h010203040506070809, chk: 8'h2D};
    tab[1] = '{payload: 72'hFFFFFFFFFFFFFFFFFF, chk: 8'hF7};
    tab[2] = '{payload: 72'h000000000000000000, chk: 8'h00};
    tab[3] = '{payload: 72'h102030405060708090, chk: 8'hD0};
    tab[4] = '{payload: 72'hFE0000000000000003, chk: 8'h01};
    exp_so = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    rst = 1'b0;
    fs = 1'b0;
    fifoc_full = 1'b0;
    set_payload(72'h0);
    repeat (3) step();
    chk("reset so", so, 8'h00);
    chk("reset fd", fd, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset txen", fifoc_txen, 1'b0);
    chk("reset txd", fifoc_txd, 8'h00);
    rst = 1'b1;
    step();

    // Cycle-exact basic frame.
    cap.delete();
    pl = 72'h010203040506070809;
    build_exp(pl);
    set_payload(pl);
    fs = 1'b1;
    step();
    fs = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("basic so c%0d", k), so, exp_so[k]);
      chk($sformatf("basic txen c%0d", k), fifoc_txen, (k >= 2 && k <= 13));
      if (k >= 2 && k <= 13) chk($sformatf("basic txd c%0d", k), fifoc_txd, exp_f[k-2]);
      chk($sformatf("basic fd c%0d", k), fd, (k == 14));
      if (k < 14) step();
    end
    step();
    chk("basic back to idle", so, 8'h00);
    cmp_frame("basic");

    // Table of payloads with hand-computed checksums.
    for (int v = 0; v < 5; v++) begin
      send_frame(tab[v].payload, 1'b0, cyc);
      build_exp(tab[v].payload);
      chk($sformatf("tab%0d latency", v), cyc, 14);
      cmp_frame($sformatf("tab%0d", v));
      if (cap.size() == 12) chk($sformatf("tab%0d chk", v), cap[11], tab[v].chk);
    end

    // Backpressure in CMD3 for five cycles.
    cap.delete();
    pl = 72'h010203040506070809;
    build_exp(pl);
    set_payload(pl);
    fs = 1'b1;
    step();
    fs = 1'b0;
    cyc = 1;
    wait_so(8'h08, "bp reach CMD3", cyc);
    fifoc_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp txen s%0d", i), fifoc_txen, 1'b0);
      chk($sformatf("bp so s%0d", i), so, 8'h08);
      chk($sformatf("bp txd s%0d", i), fifoc_txd, 8'h04);
      step();
      cyc++;
    end
    fifoc_full = 1'b0;
    wait_so(8'h0F, "bp reach LAST", cyc);
    chk("bp latency", cyc, 19);
    cmp_frame("bp");
    cnt = 0;
    foreach (cap[i]) if (cap[i] == 8'h04) cnt++;
    chk("bp cmd_mix0 once", cnt, 1);
    step();

    // Payload inputs change after the snapshot.
    cap.delete();
    pl = 72'h112233445566778899;
    build_exp(pl);
    set_payload(pl);
    fs = 1'b1;
    step();
    fs = 1'b0;
    cyc = 1;
    wait_so(8'h07, "snap reach CMD2", cyc);
    set_payload({9{8'hAA}});
    wait_so(8'h0F, "snap reach LAST", cyc);
    cmp_frame("snap");
    step();

    // fs held high through LAST.
    cap.delete();
    set_payload(72'h0A0B0C0D0E0F101112);
    build_exp(72'h0A0B0C0D0E0F101112);
    fs = 1'b1;
    step();
    cyc = 1;
    wait_so(8'h0F, "hold reach LAST", cyc);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold fd %0d", i), fd, 1'b1);
      chk($sformatf("hold so %0d", i), so, 8'h0F);
    end
    chk("hold no second frame", cap.size(), 12);
    fs = 1'b0;
    step();
    chk("hold release idle", so, 8'h00);
    cmp_frame("hold");

    // Stall timeout from HED1.
    set_payload(72'h010203040506070809);
    fs = 1'b1;
    step();
    fs = 1'b0;
    cyc = 1;
    wait_so(8'h04, "tmo reach HED1", cyc);
    fifoc_full = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("tmo so e%0d", i), so, (i < 8) ? 8'h04 : 8'h14);
    end
    chk("tmo err", err, 1'b1);
    chk("tmo txen", fifoc_txen, 1'b0);
    chk("tmo fd", fd, 1'b0);
    fifoc_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fs = ~fs;
      step();
      chk($sformatf("tmo sticky %0d", i), so, 8'h14);
    end
    fs = 1'b0;
    rst = 1'b0;
    #1;
    chk("tmo async reset so", so, 8'h00);
    chk("tmo async reset err", err, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("tmo idle after reset", so, 8'h00);

    // Reset in CMD5, then a clean frame.
    set_payload(72'h010203040506070809);
    fs = 1'b1;
    step();
    fs = 1'b0;
    cyc = 1;
    wait_so(8'h0A, "rst reach CMD5", cyc);
    rst = 1'b0;
    #1;
    chk("midrst txen", fifoc_txen, 1'b0);
    chk("midrst so", so, 8'h00);
    chk("midrst txd", fifoc_txd, 8'h00);
    step();
    rst = 1'b1;
    step();
    send_frame(72'h5A5B5C5D5E5F606162, 1'b0, cyc);
    build_exp(72'h5A5B5C5D5E5F606162);
    chk("after rst latency", cyc, 14);
    cmp_frame("after rst");

    // Random payloads with random short FIFO-full bursts.
    for (int r = 0; r < 25; r++) begin
      pl = {$urandom(), $urandom(), 8'($urandom())};
      send_frame(pl, 1'b1, cyc);
      build_exp(pl);
      chk($sformatf("rnd%0d no err", r), err, 1'b0);
      cmp_frame($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cs2fifoc.md
Name: cs2fifoc

Overview:
Frame transmitter for the command-channel FIFO. On a start strobe it snapshots nine 8-bit status/command bytes and writes one fixed 12-byte frame into the FIFO write port: 0x55, 0xAA, nine payload bytes, then an 8-bit additive checksum. Its framing and byte order are identical to those of the command-frame parser on the receive side, so one frame format serves both directions. It sits between the control state machine (fs/fd handshake) and the transmit FIFO.

Parameters:
HEAD0, 8'h55, first header byte
HEAD1, 8'hAA, second header byte
TMO_W, 16, width of the FIFO-full stall counter
TMO_MAX, 16'hFFFF, number of consecutive stalled cycles in one byte state before ERR0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
err  out  1  high while in ERR0
fs  in  1  frame start request (level)
fd  out  1  frame done; high in LAST
so  out  8  current state code, for debug
fifoc_txen  out  1  FIFO write enable; combinational
fifoc_txd  out  8  FIFO write data; combinational
fifoc_full  in  1  FIFO full; no write is accepted while it is high
kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1  in  8 each  payload bytes, in frame order

Behaviour:
- State codes: IDLE=00, LOAD=01, HED0=03, HED1=04, CMD0..CMD8=05..0D, PART=0E, LAST=0F, ERR0=14. so equals the state code.
- Reset (rst low) takes effect immediately, including mid-frame. It forces:
  - state to IDLE;
  - fd, err and fifoc_txen to 0, and fifoc_txd to 00;
  - shadow registers, checksum and stall counter to 0.
- IDLE: fs high at a clock edge -> LOAD. Otherwise stay in IDLE.
- LOAD (one cycle):
  - latch all nine payload inputs into shadow registers (later input changes do not affect the frame);
  - clear the checksum and the stall counter;
  - go to HED0.
- Byte states HED0, HED1, CMD0..CMD8, PART:
  - fifoc_txen = !fifoc_full.
  - fifoc_txd carries, in order: HED0, HED1, the shadow bytes in port order (CMD0=kind_dev … CMD8=cmd_mix1), then the checksum in PART.
  - When fifoc_full is low at an edge, the byte is written, the state advances one step (PART -> LAST) and the stall counter clears.
  - In CMD0..CMD8 the same write also does check <= check + byte, modulo 256 with carry discarded.
  - When fifoc_full is high, the state holds, txen is 0, txd still shows the byte, and the stall counter increments.
  - When the stall counter reaches TMO_MAX -> ERR0.
- Checksum covers the nine payload bytes only; the header bytes are excluded.
- ERR0: sticky until reset. err=1, txen=0, fd=0.
- LAST: fd=1. fs low -> IDLE; fs still high -> stay in LAST. No new frame starts until fs has been seen low.
- fs dropping mid-frame is ignored; the frame always completes.
- Latency with FIFO never full: fs high sampled at edge 0 -> LOAD in cycle 1, HED0 in cycle 2, writes in cycles 2..13 (12 bytes), LAST (fd=1) from cycle 14.
- fifoc_txen is never high in IDLE, LOAD, LAST or ERR0.

Decomposition:
- Shared package:
  - state code constants, shared with the receive parser (same numeric codes);
  - HEAD0/HEAD1 values;
  - FRAME_LEN=12 and PAYLOAD_LEN=9.
- No sub-module: the state machine, shadow registers, byte mux and stall counter sit in one module of about 200 lines.

Test Plan:
- Basic frame: payload 01,02,03,04,05,06,07,08,09, fifoc_full=0, fs pulsed high -> FIFO receives 55 AA 01 02 03 04 05 06 07 08 09 2D on 12 consecutive cycles starting 2 cycles after fs is sampled; fd rises in cycle 14.
- Checksum wrap: all payload bytes FF -> last byte F7 (sum 0x8F7 truncated to 8 bits); header bytes not included in the sum.
- Backpressure: fifoc_full high for 5 cycles while in CMD3 -> txen=0 during those cycles; cmd_mix0 is written exactly once after full drops; frame content unchanged, completion delayed by 5 cycles.
- Snapshot: payload inputs changed to AA during CMD2 -> frame still carries the values latched in LOAD.
- Timeout: TMO_MAX=8, fifoc_full held high from HED1 -> ERR0 entered after 8 stalled cycles, err=1 and so=14; stays there while fs toggles; releasing rst returns to IDLE.
- Handshake and reset: fs held high through LAST -> fd stays 1 and no second frame is written; fs low -> IDLE next cycle. Separately, rst asserted in CMD5 -> txen=0 immediately and state=IDLE; a new fs produces a complete frame.
